// File: rtl/keccak_pkg.sv
// Types and constants shared by the Keccak-f[1600] round stages.
// A state is indexed state[x][y]; each element is one 64-bit lane.
package keccak_pkg;

    localparam int LANE_W   = 64;
    localparam int NUM_ROWS = 5;

    typedef logic [LANE_W-1:0]                    lane_t;
    typedef lane_t [NUM_ROWS-1:0]                 row_t;
    typedef lane_t [NUM_ROWS-1:0][NUM_ROWS-1:0]   state_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_HOLD
    } chi_state_e;

endpackage

// File: rtl/keccak_chi_row.sv
// Chi on one plane (fixed y): five lanes in, five lanes out, purely combinational.
module keccak_chi_row
    import keccak_pkg::*;
(
    input  row_t row_in,
    output row_t row_out
);

    // Neighbour indices fold to constants per lane, so there is no runtime modulo.
    for (genvar x = 0; x < NUM_ROWS; x++) begin : g_lane
        assign row_out[x] = row_in[x]
                          ^ (~row_in[(x + 1) % NUM_ROWS] & row_in[(x + 2) % NUM_ROWS]);
    end

endmodule

// File: rtl/keccak_chi_stage.sv
// Chi step of the Keccak-f[1600] round: updates ROWS_PER_CYCLE planes per clock in place
// and presents the registered state plus its round index to the Iota stage.
module keccak_chi_stage #(
    parameter int ROWS_PER_CYCLE = 1,
    parameter int LANE_W         = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         round_in,
    input  keccak_pkg::state_t  A,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         round_out,
    output keccak_pkg::state_t  Ab
);
    import keccak_pkg::*;

    localparam int R = ROWS_PER_CYCLE;

    if (!(R == 1 || R == 5)) begin : g_bad_rows
        $error("keccak_chi_stage: ROWS_PER_CYCLE must be 1 or 5");
    end
    if (LANE_W != 64) begin : g_bad_lane
        $error("keccak_chi_stage: LANE_W must be 64");
    end

    chi_state_e  fsm_q, fsm_d;
    logic [2:0]  row_cnt_q, row_cnt_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] round_q, round_d;
    state_t      work_q, work_d;

    logic [R-1:0][2:0] row_sel;
    row_t [R-1:0]      row_in;
    row_t [R-1:0]      row_out;
    logic              last_rows;

    // Row-select mux in front of each chi row instance.
    for (genvar g = 0; g < R; g++) begin : g_row
        assign row_sel[g] = row_cnt_q + 3'(g);
        for (genvar x = 0; x < NUM_ROWS; x++) begin : g_sel
            assign row_in[g][x] = work_q[x][row_sel[g]];
        end
        keccak_chi_row u_row (
            .row_in  (row_in[g]),
            .row_out (row_out[g])
        );
    end

    assign last_rows = (row_cnt_q == 3'(NUM_ROWS - R));

    always_comb begin
        fsm_d       = fsm_q;
        row_cnt_d   = row_cnt_q;
        out_valid_d = out_valid_q;
        round_d     = round_q;
        work_d      = work_q;
        unique case (fsm_q)
            ST_IDLE: begin
                if (in_valid) begin
                    work_d    = A;
                    round_d   = round_in;
                    row_cnt_d = 3'd0;
                    fsm_d     = ST_CALC;
                end
            end
            ST_CALC: begin
                // Chi only mixes lanes of one plane, so overwriting in place is exact.
                for (int g = 0; g < R; g++) begin
                    for (int x = 0; x < NUM_ROWS; x++) begin
                        work_d[x][row_sel[g]] = row_out[g][x];
                    end
                end
                row_cnt_d = row_cnt_q + 3'(R);
                if (last_rows) begin
                    fsm_d       = ST_HOLD;
                    out_valid_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    fsm_d       = ST_IDLE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q       <= ST_IDLE;
            row_cnt_q   <= 3'd0;
            out_valid_q <= 1'b0;
            round_q     <= 32'd0;
            work_q      <= '0;
        end else begin
            fsm_q       <= fsm_d;
            row_cnt_q   <= row_cnt_d;
            out_valid_q <= out_valid_d;
            round_q     <= round_d;
            work_q      <= work_d;
        end
    end

    assign in_ready  = (fsm_q == ST_IDLE) && !reset;
    assign out_valid = out_valid_q;
    assign round_out = round_q;
    assign Ab        = work_q;

endmodule

// File: tb/tb_keccak_chi_stage.sv
// Directed bench for keccak_chi_stage with one row per clock and with all five rows per clock.
module tb_keccak_chi_stage;
    import keccak_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        iv1, ir1, ov1, or1;
    logic [31:0] ri1, ro1;
    state_t      a1, ab1;
    logic        iv5, ir5, ov5, or5;
    logic [31:0] ri5, ro5;
    state_t      a5, ab5;

    int checks = 0;
    int errors = 0;

    keccak_chi_stage #(.ROWS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1), .round_in(ri1), .A(a1),
        .out_valid(ov1), .out_ready(or1), .round_out(ro1), .Ab(ab1)
    );

    keccak_chi_stage #(.ROWS_PER_CYCLE(5)) u_dut5 (
        .clk(clk), .reset(reset), .in_valid(iv5), .in_ready(ir5), .round_in(ri5), .A(a5),
        .out_valid(ov5), .out_ready(or5), .round_out(ro5), .Ab(ab5)
    );

    function automatic state_t chi_model(input state_t s);
        state_t r;
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                r[x][y] = s[x][y] ^ (~s[(x + 1) % 5][y] & s[(x + 2) % 5][y]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input state_t obs, input state_t exp);
        int fx = 0;
        int fy = 0;
        for (int x = 4; x >= 0; x--)
            for (int y = 4; y >= 0; y--)
                if (obs[x][y] !== exp[x][y]) begin
                    fx = x;
                    fy = y;
                end
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s lane[%0d][%0d] observed=%h expected=%h",
                   tag, fx, fy, obs[fx][fy], exp[fx][fy]);
        end
    endtask

    // Waits for out_valid on the one-row DUT; returns cycles from the accept edge.
    task automatic wait_ov1(output int lat);
        lat = 0;
        while (!ov1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run1(input string tag, input state_t a, input logic [31:0] r,
                        input state_t exp, input logic [31:0] rexp);
        int lat;
        a1  = a;
        ri1 = r;
        iv1 = 1'b1;
        @(negedge clk);
        iv1 = 1'b0;
        wait_ov1(lat);
        chk({tag, "_latency"}, 64'(lat), 64'd5);
        chk_state({tag, "_ab"}, ab1, exp);
        chk({tag, "_round"}, ro1, rexp);
        or1 = 1'b1;
        @(negedge clk);
        chk({tag, "_ov_drop"}, ov1, 1'b0);
        chk({tag, "_ready"}, ir1, 1'b1);
        or1 = 1'b0;
    endtask

    state_t zero_s, va, ea, vb, eb, vc, ec, garbage;
    state_t list5 [3];
    int     acc5 [3];
    int     lat, sent, got;

    initial begin
        reset = 1'b1;
        iv1 = 1'b0; or1 = 1'b0; ri1 = '0; a1 = '0;
        iv5 = 1'b0; or5 = 1'b0; ri5 = '0; a5 = '0;
        zero_s = '0;

        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", ir1, 1'b0);
        chk("rst_out_valid", ov1, 1'b0);
        chk("rst_round_out", ro1, 32'd0);
        chk_state("rst_ab", ab1, zero_s);
        chk("rst_in_ready5", ir5, 1'b0);
        chk("rst_out_valid5", ov5, 1'b0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", ir1, 1'b1);

        run1("zero", zero_s, 32'd0, zero_s, 32'd0);

        va = '0; va[2][0] = 64'h1;
        ea = '0; ea[0][0] = 64'h1; ea[2][0] = 64'h1;
        run1("lane20", va, 32'd23, ea, 32'd23);

        vb = '0; vb[2][3] = '1;
        eb = '0; eb[0][3] = '1; eb[2][3] = '1;
        run1("row3", vb, 32'd7, eb, 32'd7);

        // Row 1: x0=F, x1=P -> x0=F, x1=P, x3=F; in_valid left high with garbage must be ignored.
        vc = '0; vc[0][1] = 64'hFFFF_FFFF_FFFF_FFFF; vc[1][1] = 64'h0F0F_0F0F_0F0F_0F0F;
        ec = '0; ec[0][1] = 64'hFFFF_FFFF_FFFF_FFFF; ec[1][1] = 64'h0F0F_0F0F_0F0F_0F0F;
        ec[3][1] = 64'hFFFF_FFFF_FFFF_FFFF;
        a1 = vc; ri1 = 32'd30; iv1 = 1'b1;
        @(negedge clk);
        garbage = '1;
        garbage[4][4] = 64'h1234;
        a1 = garbage; ri1 = 32'd5;
        wait_ov1(lat);
        chk("bp_latency", 64'(lat), 64'd5);
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_valid", ov1, 1'b1);
            chk("bp_in_ready", ir1, 1'b0);
            chk_state("bp_ab", ab1, ec);
            chk("bp_round", ro1, 32'd30);
            @(negedge clk);
        end
        or1 = 1'b1;
        @(negedge clk);
        chk("bp_ov_drop", ov1, 1'b0);
        chk("bp_ready", ir1, 1'b1);
        iv1 = 1'b0;
        or1 = 1'b0;
        @(negedge clk);
        chk("bp_no_requeue", ov1, 1'b0);

        a1 = va; ri1 = 32'd9; iv1 = 1'b1;
        @(negedge clk);
        iv1 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_ov", ov1, 1'b0);
        chk_state("mid_rst_ab", ab1, zero_s);
        chk("mid_rst_round", ro1, 32'd0);
        chk("mid_rst_ready_hi", ir1, 1'b0);
        reset = 1'b0;
        #1;
        chk("mid_rst_ready", ir1, 1'b1);
        @(negedge clk);
        run1("after_rst", va, 32'd11, ea, 32'd11);

        for (int k = 0; k < 3; k++)
            for (int x = 0; x < 5; x++)
                for (int y = 0; y < 5; y++)
                    list5[k][x][y] = {$urandom, $urandom};
        sent = 0;
        got  = 0;
        or5  = 1'b1;
        for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
            @(negedge clk);
            if (ov5) begin
                chk("r5_latency", 64'(cyc - acc5[got] - 1), 64'd1);
                chk_state("r5_ab", ab5, chi_model(list5[got]));
                chk("r5_round", ro5, 32'(100 + got));
                got++;
            end
            if (ir5 && sent < 3) begin
                a5   = list5[sent];
                ri5  = 32'(100 + sent);
                iv5  = 1'b1;
                acc5[sent] = cyc;
                sent++;
            end else if (sent >= 3) begin
                iv5 = 1'b0;
            end
        end
        chk("r5_delivered", 64'(got), 64'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
